// File: rtl/sram_ctrl_if.sv
// +----------------------------------------------------------------------+
// | Module      : sram_ctrl_if                                           |
// | Description : Request/response bundle between the LC-3 memory stage  |
// |               and the SRAM controller.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

interface sram_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [1:0]        be;
  logic              busy;
  logic              done;
  logic [15:0]       rdata;

  // Requester side: issues a transfer and watches for completion.
  modport master (
    output req, wr, addr, wdata, be,
    input  busy, done, rdata
  );

  // Controller side.
  modport slave (
    input  req, wr, addr, wdata, be,
    output busy, done, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : sram_ctrl                                              |
// | Description : Single-transfer controller for an asynchronous 16-bit  |
// |               SRAM. Sequences CE/UB/LB/OE/WE with a programmable     |
// |               wait-state count and owns the bidirectional data bus.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,   // OE/WE active cycles, 1..15
  parameter int ADDR_W      = 20
) (
  input  wire               Clk,
  input  wire               Reset,  // asynchronous, active-low
  sram_ctrl_if.slave        bus,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [15:0]       Data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wdata_q;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q;
  logic        accept, rd_last;
  logic        ce_d, ub_d, lb_d, oe_d, we_d, drv_d, drv_q;

  // Next-state and wait counter; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'd0;
          state_d = bus.wr ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == C_LAST) begin
          rd_last = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == C_LAST) state_d = S_WR_HOLD;
        else                 cnt_d   = cnt_q + 4'd1;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they can be registered
  // and still change on the same edge as the state itself.
  always_comb begin
    be_d  = accept ? bus.be : be_q;
    ce_d  = 1'b1;
    oe_d  = 1'b1;
    we_d  = 1'b1;
    ub_d  = 1'b1;
    lb_d  = 1'b1;
    drv_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        ub_d = ~be_d[1];
        lb_d = ~be_d[0];
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_d  = 1'b0;
        ub_d  = ~be_d[1];
        lb_d  = ~be_d[0];
        drv_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_d  = 1'b0;
        we_d  = 1'b0;
        ub_d  = ~be_d[1];
        lb_d  = ~be_d[0];
        drv_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched request and registered pin drivers; reset releases all
  // strobes and the data bus without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      rdata_q <= 16'h0000;
      ADDR    <= '0;
      CE      <= 1'b1;
      UB      <= 1'b1;
      LB      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      if (accept) begin
        ADDR    <= bus.addr;
        wdata_q <= bus.wdata;
      end
      // Disabled byte lanes read back as zero.
      if (rd_last) begin
        rdata_q <= {be_q[1] ? Data[15:8] : 8'h00,
                    be_q[0] ? Data[7:0]  : 8'h00};
      end
      CE    <= ce_d;
      UB    <= ub_d;
      LB    <= lb_d;
      OE    <= oe_d;
      WE    <= we_d;
      drv_q <= drv_d;
    end
  end

  assign Data      = drv_q ? wdata_q : 16'hzzzz;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.rdata = rdata_q;

endmodule

`default_nettype wire
